vga_sync_gen: RTL and testbench

//   VGA timing generator feeding the pixel/pattern stage of the tt_um_devinatkin VGA design.

---
 rtl/vga_sync_gen.sv | 111 +++++++++++
 tb/tb_vga_sync_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock into a pixel strobe and runs
// the horizontal/vertical counters that produce sync, blanking and line/frame markers.
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic       pix_stb,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Window bounds kept 11 bits wide so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VIS);
    localparam logic [10:0] V_VIS_END = 11'(V_VIS);
    localparam logic [10:0] HS_START  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [9:0]       hpos_reg, hpos_next;
    logic [9:0]       vpos_reg, vpos_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             display_reg, display_next;
    logic             stb;
    logic             hs_act, vs_act;

    assign stb = (div_cnt_reg == DIV_LAST);

    always_comb begin
        div_cnt_next = stb ? '0 : div_cnt_reg + 1'b1;
        hpos_next    = hpos_reg;
        vpos_next    = vpos_reg;
        if (stb) begin
            if (hpos_reg == H_LAST) begin
                hpos_next = '0;
                vpos_next = (vpos_reg == V_LAST) ? '0 : vpos_reg + 1'b1;
            end else begin
                hpos_next = hpos_reg + 1'b1;
            end
        end
        // Restart wins over any advance happening on the same edge.
        if (restart) begin
            div_cnt_next = '0;
            hpos_next    = '0;
            vpos_next    = '0;
        end
    end

    // Sync and blanking are decoded from the next counts so they line up with hpos/vpos.
    always_comb begin
        hs_act       = ({1'b0, hpos_next} >= HS_START) && ({1'b0, hpos_next} < HS_END);
        vs_act       = ({1'b0, vpos_next} >= VS_START) && ({1'b0, vpos_next} < VS_END);
        hsync_next   = hs_act ? SYNC_POL : ~SYNC_POL;
        vsync_next   = vs_act ? SYNC_POL : ~SYNC_POL;
        display_next = ({1'b0, hpos_next} < H_VIS_END) && ({1'b0, vpos_next} < V_VIS_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            hpos_reg    <= '0;
            vpos_reg    <= '0;
            hsync_reg   <= ~SYNC_POL;
            vsync_reg   <= ~SYNC_POL;
            display_reg <= 1'b1;
        end else begin
            div_cnt_reg <= div_cnt_next;
            hpos_reg    <= hpos_next;
            vpos_reg    <= vpos_next;
            hsync_reg   <= hsync_next;
            vsync_reg   <= vsync_next;
            display_reg <= display_next;
        end
    end

    assign pix_stb     = stb;
    assign hpos        = hpos_reg;
    assign vpos        = vpos_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign display_on  = display_reg;
    assign line_start  = stb && (hpos_reg == '0);
    assign frame_start = stb && (hpos_reg == '0) && (vpos_reg == '0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance for line/reset/restart timing
// and a tiny active-high-sync instance so a full frame wrap fits in a short run.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart_a = 1'b0;
    logic       restart_b = 1'b0;
    logic       pix_stb_a, hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a;
    logic [9:0] hpos_a, vpos_a;
    logic       pix_stb_b, hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b;
    logic [9:0] hpos_b, vpos_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_gen dut_a (
        .clk(clk), .rst(rst), .restart(restart_a), .pix_stb(pix_stb_a),
        .hpos(hpos_a), .vpos(vpos_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(display_on_a), .line_start(line_start_a), .frame_start(frame_start_a)
    );

    // Tiny timing: H total 15, V total 8, 2 clks per pixel, active-high syncs.
    vga_sync_gen #(
        .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .restart(restart_b), .pix_stb(pix_stb_b),
        .hpos(hpos_b), .vpos(vpos_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(display_on_b), .line_start(line_start_b), .frame_start(frame_start_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb_a(output int n);
        n = 0;
        do begin tick(); n++; end while (pix_stb_a !== 1'b1 && n < 20);
        if (pix_stb_a !== 1'b1) check("stb_a_timeout", 32'(pix_stb_a), 1);
    endtask

    task automatic wait_stb_b(output int n);
        n = 0;
        do begin tick(); n++; end while (pix_stb_b !== 1'b1 && n < 20);
        if (pix_stb_b !== 1'b1) check("stb_b_timeout", 32'(pix_stb_b), 1);
    endtask

    initial begin
        int n, t0, k, hs_cnt, hs_first, dis_off, seen;
        int ph, pv, vs_cnt, vs_first, dis_cnt;

        // Reset state, then release between edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_stb", 32'(pix_stb_a), 0);
        check("rst_line_start", 32'(line_start_a), 0);
        rst = 1'b0;
        #1;
        check("rel_hpos", 32'(hpos_a), 0);
        check("rel_vpos", 32'(vpos_a), 0);
        check("rel_hsync", 32'(hsync_a), 1);
        check("rel_vsync", 32'(vsync_a), 1);
        check("rel_display_on", 32'(display_on_a), 1);

        wait_stb_a(n);
        check("first_stb_latency", 32'(n), 3);
        check("first_stb_frame_start", 32'(frame_start_a), 1);
        t0 = cyc;
        wait_stb_a(n);
        check("stb_period", 32'(n), 4);
        check("second_stb_hpos", 32'(hpos_a), 1);

        // Walk the rest of line 0 sampling each strobe.
        hs_cnt = 0; hs_first = -1; dis_off = -1; k = 0;
        while (k < 900) begin
            wait_stb_a(n);
            k++;
            if (hpos_a == 10'd0) break;
            if (hsync_a == 1'b0) begin
                if (hs_first < 0) hs_first = int'(hpos_a);
                hs_cnt++;
            end
            if (display_on_a == 1'b0 && dis_off < 0) dis_off = int'(hpos_a);
        end
        check("hsync_low_strobes", 32'(hs_cnt), 96);
        check("hsync_first_hpos", 32'(hs_first), 656);
        check("display_off_hpos", 32'(dis_off), 640);
        check("line1_vpos", 32'(vpos_a), 1);
        check("line1_line_start", 32'(line_start_a), 1);
        check("line1_frame_start", 32'(frame_start_a), 0);
        check("line1_display_on", 32'(display_on_a), 1);
        check("line_period_clks", 32'(cyc - t0), 3200);

        // Async reset mid-line at hpos 700, applied between edges.
        k = 0;
        while (hpos_a != 10'd700 && k < 900) begin wait_stb_a(n); k++; end
        check("pre_rst_hpos", 32'(hpos_a), 700);
        check("pre_rst_hsync", 32'(hsync_a), 0);
        check("pre_rst_display", 32'(display_on_a), 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hpos", 32'(hpos_a), 0);
        check("async_rst_vpos", 32'(vpos_a), 0);
        check("async_rst_hsync", 32'(hsync_a), 1);
        check("async_rst_display", 32'(display_on_a), 1);
        check("async_rst_pix_stb", 32'(pix_stb_a), 0);
        #1 rst = 1'b0;
        wait_stb_a(n);
        check("post_rst_latency", 32'(n), 3);
        check("post_rst_frame_start", 32'(frame_start_a), 1);

        // Restart coinciding with the strobe at hpos 10.
        k = 0;
        while (hpos_a != 10'd10 && k < 40) begin wait_stb_a(n); k++; end
        check("pre_restart_hpos", 32'(hpos_a), 10);
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        check("restart_hpos", 32'(hpos_a), 0);
        check("restart_vpos", 32'(vpos_a), 0);
        check("restart_pix_stb", 32'(pix_stb_a), 0);
        wait_stb_a(n);
        check("restart_latency", 32'(n), 3);
        check("restart_stb_hpos", 32'(hpos_a), 0);

        // Restart held: timing frozen, no strobes.
        restart_a = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (pix_stb_a == 1'b1) seen++;
        end
        check("held_restart_stbs", 32'(seen), 0);
        check("held_restart_hpos", 32'(hpos_a), 0);
        restart_a = 1'b0;
        wait_stb_a(n);
        check("held_release_latency", 32'(n), 3);

        // Tiny instance: reset polarity, then one full frame up to the wrap.
        rst = 1'b1;
        #2;
        check("b_rst_hsync", 32'(hsync_b), 0);
        check("b_rst_vsync", 32'(vsync_b), 0);
        check("b_rst_display", 32'(display_on_b), 1);
        tick();
        rst = 1'b0;
        wait_stb_b(n);
        check("b_first_latency", 32'(n), 1);
        check("b_first_frame_start", 32'(frame_start_b), 1);
        t0 = cyc;
        vs_cnt = 0; vs_first = -1; hs_cnt = 0; dis_cnt = int'(display_on_b);
        ph = 0; pv = 0; k = 0;
        while (k < 200) begin
            ph = int'(hpos_b);
            pv = int'(vpos_b);
            wait_stb_b(n);
            k++;
            if (frame_start_b == 1'b1) break;
            if (vsync_b == 1'b1) begin
                if (vs_first < 0) vs_first = int'(vpos_b);
                vs_cnt++;
            end
            if (hsync_b == 1'b1) hs_cnt++;
            if (display_on_b == 1'b1) dis_cnt++;
        end
        check("b_vsync_strobes", 32'(vs_cnt), 30);
        check("b_vsync_first_vpos", 32'(vs_first), 5);
        check("b_hsync_strobes", 32'(hs_cnt), 24);
        check("b_display_strobes", 32'(dis_cnt), 32);
        check("b_prewrap_hpos", 32'(ph), 14);
        check("b_prewrap_vpos", 32'(pv), 7);
        check("b_wrap_hpos", 32'(hpos_b), 0);
        check("b_wrap_vpos", 32'(vpos_b), 0);
        check("b_wrap_line_start", 32'(line_start_b), 1);
        check("b_frame_period", 32'(cyc - t0), 240);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
